// File: rtl/fpu_cmd_pkg.sv
// Shared types and constants for the UART-driven FPU command sequencer.
package fpu_cmd_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_DIV = 2'b10,
      OP_SUB = 2'b11
   } opsel_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RX_A   = 3'd1,
      S_RX_B   = 3'd2,
      S_LAUNCH = 3'd3,
      S_WAIT   = 3'd4,
      S_TX     = 3'd5
   } seq_state_t;

   // Quiet NaN handed back to the host when the core never answers.
   localparam logic [31:0] NAN_RESULT_DEFAULT = 32'h7FC0_0000;

   // One opcode byte followed by two 4-byte operands.
   localparam int FRAME_LEN = 9;

   // Index of the final byte of an operand (or of the result) in the byte counter.
   localparam logic [1:0] LAST_BYTE = 2'((FRAME_LEN - 1) / 2 - 1);

   // Picks result bytes most-significant first as the counter walks 0..3.
   function automatic logic [7:0] resultByte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] sel;
      case (idx)
         2'd0:    sel = word[31:24];
         2'd1:    sel = word[23:16];
         2'd2:    sel = word[15:8];
         default: sel = word[7:0];
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fpu_seq_timer.sv
// Watchdog counter: counts enabled cycles and pulses once after TIMEOUT of them.
module fpu_seq_timer #(
   parameter int TIMEOUT = 4096,
   parameter int WIDTH   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(TIMEOUT - 1);

   logic [WIDTH-1:0] r_count;

   // Count enabled cycles; a clear always wins and the count restarts after expiry.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         if (r_count == LAST_COUNT) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + WIDTH'(1);
         end
      end
   end

   assign o_expired = i_enable && !i_clear && (r_count == LAST_COUNT);

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Collects a 9-byte command frame from the UART, runs one FPU operation and
// streams the 32-bit result back MSB first, with watchdogs on both sides.
module fpu_cmd_sequencer
   import fpu_cmd_pkg::*;
#(
   parameter int          FRAME_TIMEOUT = 2_000_000,
   parameter int          FPU_TIMEOUT   = 4096,
   parameter logic [31:0] NAN_RESULT    = NAN_RESULT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [1:0]  fpu_opsel,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_start,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result,
   output logic        busy,
   output logic        frame_err
);

   seq_state_t  r_state;
   seq_state_t  w_nextState;
   logic [1:0]  r_cnt;
   opsel_t      r_opsel;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_result;

   logic w_inRx;
   logic w_frameExpired;
   logic w_fpuExpired;
   logic w_frameErr;

   assign w_inRx = (r_state == S_RX_A) || (r_state == S_RX_B);

   // Inter-byte watchdog: only runs while a frame is half-assembled.
   fpu_seq_timer #(
      .TIMEOUT (FRAME_TIMEOUT)
   ) u_frameTimer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (rx_valid || !w_inRx),
      .i_enable  (w_inRx),
      .o_expired (w_frameExpired)
   );

   // Completion watchdog: only runs while waiting on the core.
   fpu_seq_timer #(
      .TIMEOUT (FPU_TIMEOUT)
   ) u_fpuTimer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (r_state != S_WAIT),
      .i_enable  (r_state == S_WAIT),
      .o_expired (w_fpuExpired)
   );

   // Next-state and error-pulse decode; an arriving byte beats a same-cycle frame timeout.
   always_comb begin
      w_nextState = r_state;
      w_frameErr  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (rx_valid) w_nextState = S_RX_A;
         end
         S_RX_A: begin
            if (rx_valid) begin
               if (r_cnt == LAST_BYTE) w_nextState = S_RX_B;
            end else if (w_frameExpired) begin
               w_nextState = S_IDLE;
               w_frameErr  = 1'b1;
            end
         end
         S_RX_B: begin
            if (rx_valid) begin
               if (r_cnt == LAST_BYTE) w_nextState = S_LAUNCH;
            end else if (w_frameExpired) begin
               w_nextState = S_IDLE;
               w_frameErr  = 1'b1;
            end
         end
         S_LAUNCH: begin
            w_nextState = S_WAIT;
            if (rx_valid) w_frameErr = 1'b1;
         end
         S_WAIT: begin
            if (fpu_done) begin
               w_nextState = S_TX;
            end else if (w_fpuExpired) begin
               w_nextState = S_TX;
               w_frameErr  = 1'b1;
            end
            if (rx_valid) w_frameErr = 1'b1;
         end
         S_TX: begin
            if (tx_ready && (r_cnt == LAST_BYTE)) w_nextState = S_IDLE;
            if (rx_valid) w_frameErr = 1'b1;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // State register plus the byte counter, operand and result registers it steers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 2'd0;
         r_opsel  <= OP_ADD;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_result <= 32'd0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 2'd0;
               if (rx_valid) r_opsel <= opsel_t'(rx_data[1:0]);
            end
            S_RX_A: begin
               if (rx_valid) begin
                  r_a[{r_cnt, 3'b000} +: 8] <= rx_data;
                  r_cnt                     <= r_cnt + 2'd1;
               end
            end
            S_RX_B: begin
               if (rx_valid) begin
                  r_b[{r_cnt, 3'b000} +: 8] <= rx_data;
                  r_cnt                     <= r_cnt + 2'd1;
               end
            end
            S_WAIT: begin
               r_cnt <= 2'd0;
               if (fpu_done) begin
                  r_result <= fpu_result;
               end else if (w_fpuExpired) begin
                  r_result <= NAN_RESULT;
               end
            end
            S_TX: begin
               if (tx_ready) r_cnt <= r_cnt + 2'd1;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign tx_valid  = (r_state == S_TX);
   assign tx_data   = tx_valid ? resultByte(r_result, r_cnt) : 8'd0;
   assign fpu_start = (r_state == S_LAUNCH);
   assign fpu_opsel = r_opsel;
   assign fpu_a     = r_a;
   assign fpu_b     = r_b;
   assign busy      = (r_state != S_IDLE);
   assign frame_err = w_frameErr;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer: a scoreboard queue holds the bytes the
// host should receive, and a negedge monitor pops and compares every transfer.
module tb_fpu_cmd_sequencer;
   import fpu_cmd_pkg::*;

   localparam int FRAME_TO = 100;
   localparam int FPU_TO   = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  fpu_opsel;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic        fpu_start;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic        busy;
   logic        frame_err;

   int nVectors   = 0;
   int nMiss      = 0;
   int errCount   = 0;
   int startCount = 0;
   int txCount    = 0;

   logic [7:0] expQ[$];
   logic       stallPrev = 1'b0;
   logic [7:0] stallData = 8'd0;

   fpu_cmd_sequencer #(
      .FRAME_TIMEOUT (FRAME_TO),
      .FPU_TIMEOUT   (FPU_TO),
      .NAN_RESULT    (32'h7FC0_0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .fpu_opsel  (fpu_opsel),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_start  (fpu_start),
      .fpu_done   (fpu_done),
      .fpu_result (fpu_result),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'd0;
   endtask

   task automatic pushResult(input logic [31:0] r);
      for (int i = 3; i >= 0; i--) expQ.push_back(r[8*i +: 8]);
   endtask

   // Sends a full frame and checks launch latency and the operands presented to the core.
   task automatic sendFrame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [1:0] expOp;
      expOp = op[1:0];
      applyStimulus(op);
      for (int i = 0; i < 4; i++) applyStimulus(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) applyStimulus(b[8*i +: 8]);
      checkOutput("startLatency", {31'd0, fpu_start}, 32'd1);
      checkOutput("opsel", {30'd0, fpu_opsel}, {30'd0, expOp});
      checkOutput("operandA", fpu_a, a);
      checkOutput("operandB", fpu_b, b);
   endtask

   // Plays the FPU: answers after lat cycles and queues the bytes the host should see.
   task automatic runFpu(input logic [31:0] result, input int lat);
      repeat (lat) tick();
      fpu_result = result;
      fpu_done   = 1'b1;
      pushResult(result);
      tick();
      fpu_done   = 1'b0;
      checkOutput("txLatency", {31'd0, tx_valid}, 32'd1);
      checkOutput("txFirst", {24'd0, tx_data}, {24'd0, result[31:24]});
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
      tick();
      checkOutput("idleAfterTx", {31'd0, busy}, 32'd0);
   endtask

   // Monitor: scores every TX transfer, checks stalled bytes hold, and counts pulses.
   always @(negedge clk) begin
      if (stallPrev) begin
         checkOutput("txHoldValid", {31'd0, tx_valid}, 32'd1);
         checkOutput("txHoldData", {24'd0, tx_data}, {24'd0, stallData});
      end
      stallPrev = tx_valid && !tx_ready && !reset;
      stallData = tx_data;
      if (frame_err)  errCount++;
      if (fpu_start)  startCount++;
      if (tx_valid && tx_ready) begin
         txCount++;
         if (expQ.size() == 0) begin
            nVectors++;
            nMiss++;
            $error("[TB] FAIL txUnexpected observed=%h expected=none", tx_data);
         end else begin
            checkOutput("txByte", {24'd0, tx_data}, {24'd0, expQ.pop_front()});
         end
      end
   end

   initial begin
      int e0;
      int s0;
      int t0;
      int n;

      reset      = 1'b1;
      rx_valid   = 1'b0;
      rx_data    = 8'd0;
      tx_ready   = 1'b1;
      fpu_done   = 1'b0;
      fpu_result = 32'd0;
      repeat (3) tick();
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstTxValid", {31'd0, tx_valid}, 32'd0);
      checkOutput("rstStart", {31'd0, fpu_start}, 32'd0);
      checkOutput("rstErr", {31'd0, frame_err}, 32'd0);
      checkOutput("rstTxData", {24'd0, tx_data}, 32'd0);
      checkOutput("rstOpsel", {30'd0, fpu_opsel}, 32'd0);
      checkOutput("rstA", fpu_a, 32'd0);
      checkOutput("rstB", fpu_b, 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] add 3.5 + 2.0");
      sendFrame(8'h00, 32'h4060_0000, 32'h4000_0000);
      runFpu(32'h40B0_0000, 3);
      waitDrain(20);

      $display("[TB] div with ignored opcode bits, byte dropped while waiting");
      sendFrame(8'h06, 32'h51A9_54D5, 32'h4110_0000);
      checkOutput("opselDiv", {30'd0, fpu_opsel}, {30'd0, OP_DIV});
      tick();
      e0 = errCount;
      applyStimulus(8'hAA);
      checkOutput("dropErr", 32'(errCount), 32'(e0 + 1));
      checkOutput("dropBusy", {31'd0, busy}, 32'd1);
      runFpu(32'h5016_844C, 2);
      waitDrain(20);

      $display("[TB] fpu_done while idle is ignored");
      fpu_result = 32'hDEAD_BEEF;
      fpu_done   = 1'b1;
      tick();
      fpu_done   = 1'b0;
      tick();
      checkOutput("strayDoneBusy", {31'd0, busy}, 32'd0);
      checkOutput("strayDoneTx", {31'd0, tx_valid}, 32'd0);

      $display("[TB] partial frame timeout");
      s0 = startCount;
      e0 = errCount;
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'hC0);
      repeat (FRAME_TO - 10) tick();
      checkOutput("ftoEarlyBusy", {31'd0, busy}, 32'd1);
      checkOutput("ftoEarlyErr", 32'(errCount), 32'(e0));
      n = 0;
      while (errCount == e0 && n < 40) begin
         tick();
         n++;
      end
      checkOutput("ftoErr", 32'(errCount), 32'(e0 + 1));
      tick();
      checkOutput("ftoIdle", {31'd0, busy}, 32'd0);
      checkOutput("ftoNoStart", 32'(startCount), 32'(s0));
      sendFrame(8'h01, 32'h3FC0_0000, 32'h4000_0000);
      runFpu(32'h4040_0000, 1);
      waitDrain(20);

      $display("[TB] fpu never answers");
      e0 = errCount;
      sendFrame(8'h03, 32'h3F80_0000, 32'h3F80_0000);
      pushResult(32'h7FC0_0000);
      repeat (FPU_TO - 10) tick();
      checkOutput("fpuToEarlyTx", {31'd0, tx_valid}, 32'd0);
      checkOutput("fpuToEarlyBusy", {31'd0, busy}, 32'd1);
      n = 0;
      while (!tx_valid && n < 30) begin
         tick();
         n++;
      end
      checkOutput("fpuToTx", {31'd0, tx_valid}, 32'd1);
      checkOutput("fpuToErr", 32'(errCount), 32'(e0 + 1));
      waitDrain(20);

      $display("[TB] tx back-pressure");
      tx_ready = 1'b0;
      sendFrame(8'h01, 32'h4000_0000, 32'h4040_0000);
      runFpu(32'h40C0_0000, 1);
      for (int i = 0; i < 4; i++) begin
         repeat (50) tick();
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
      end
      checkOutput("stallDrain", 32'(expQ.size()), 32'd0);
      tick();
      checkOutput("stallIdle", {31'd0, busy}, 32'd0);
      tx_ready = 1'b1;

      $display("[TB] reset while receiving operand B");
      applyStimulus(8'h00);
      for (int i = 0; i < 6; i++) applyStimulus(8'h11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rxRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rxRstA", fpu_a, 32'd0);
      checkOutput("rxRstStart", {31'd0, fpu_start}, 32'd0);
      tick();
      sendFrame(8'h00, 32'h3F80_0000, 32'h4000_0000);
      runFpu(32'h4040_0000, 1);
      waitDrain(20);

      $display("[TB] reset while transmitting");
      tx_ready = 1'b0;
      sendFrame(8'h02, 32'h4080_0000, 32'h4000_0000);
      runFpu(32'h4000_0000, 1);
      repeat (3) tick();
      t0    = txCount;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expQ.delete();
      checkOutput("txRstValid", {31'd0, tx_valid}, 32'd0);
      checkOutput("txRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("txRstData", {24'd0, tx_data}, 32'd0);
      tx_ready = 1'b1;
      repeat (20) tick();
      checkOutput("txRstNoBytes", 32'(txCount), 32'(t0));
      checkOutput("txRstIdle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
